tour_move_sequencer: RTL

- Sits between the tour-solving logic and the command processor.
- Once a tour is solved, it reads the stored move list one move per step and splits each knight move into two cmd_proc move legs: a vertical leg, then a horizontal leg.
- It drives cmd/cmd_rdy in place of the UART path for the length of the tour, and sends a response byte after every leg.
- It tracks the knight's board coordinates so a bench can confirm the path stays on the board.

---
 rtl/tour_pkg.sv | 38 +++
 rtl/tour_move_sequencer_if.sv | 15 +
 rtl/tour_move_sequencer_move_decode.sv | 16 +
 rtl/tour_move_sequencer.sv | 109 ++++++++++
 4 files changed

// File: rtl/tour_pkg.sv
// Shared types and constants for the knight-tour move sequencer.
package tour_pkg;
  typedef enum logic [2:0] {IDLE, VERT, WAIT_V, HORZ, WAIT_H} seq_state_t;

  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_E = 8'hBF;

  localparam logic [3:0] OP_MOVE    = 4'h2;
  localparam logic [3:0] OP_FANFARE = 4'h3;

  localparam logic [7:0] RESP_POS  = 8'hA5;
  localparam logic [7:0] RESP_MOVE = 8'h5A;

  typedef struct packed {
    logic signed [3:0] dx;
    logic signed [3:0] dy;
  } delta_t;

  // Each case value is {dx,dy} as two signed nibbles; non-one-hot words map to zero.
  function automatic delta_t move_delta(input logic [7:0] m);
    delta_t d;
    d = '0;
    case (m)
      8'h01: d = 8'h12;
      8'h02: d = 8'hF2;
      8'h04: d = 8'hE1;
      8'h08: d = 8'hEF;
      8'h10: d = 8'hFE;
      8'h20: d = 8'h1E;
      8'h40: d = 8'h2F;
      8'h80: d = 8'h21;
      default: d = '0;
    endcase
    return d;
  endfunction
endpackage

// File: rtl/tour_move_sequencer_if.sv
// Command/response path shared between cmd_proc, the UART wrapper and the sequencer.
interface tour_move_sequencer_if;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic [7:0]  resp;

  modport master (output cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
                  input  cmd, cmd_rdy, resp);
  modport slave  (input  cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
                  output cmd, cmd_rdy, resp);
endinterface

// File: rtl/tour_move_sequencer_move_decode.sv
// Combinational one-hot knight move to signed (dx,dy) plus legality flag.
module move_decode
  import tour_pkg::*;
(
  input  logic [7:0]        move,
  output logic signed [3:0] dx,
  output logic signed [3:0] dy,
  output logic              valid
);
  delta_t d;

  assign d     = move_delta(move);
  assign dx    = d.dx;
  assign dy    = d.dy;
  assign valid = $onehot(move);
endmodule

// File: rtl/tour_move_sequencer.sv
// Replays a solved knight tour as vertical-then-horizontal cmd_proc legs,
// owning the cmd path while active and tracking the knight's coordinates.
module tour_move_sequencer
  import tour_pkg::*;
#(
  parameter int NUM_MOVES = 24,
  parameter int BRD_MAX   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_tour,
  input  logic [2:0]                x_start,
  input  logic [2:0]                y_start,
  input  logic [7:0]                move,
  output logic [4:0]                mv_indx,
  tour_move_sequencer_if.slave      bus,
  output logic                      tour_active,
  output logic [2:0]                cur_x,
  output logic [2:0]                cur_y,
  output logic                      mv_err
);
  localparam logic [4:0]        LAST = 5'(NUM_MOVES - 1);
  localparam logic signed [3:0] BMAX = 4'(BRD_MAX);

  seq_state_t        state;
  logic signed [3:0] dx, dy, nx, ny;
  logic              valid, last;
  logic [15:0]       cmd_int;
  logic              cmd_rdy_int;

  move_decode u_dec (.move(move), .dx(dx), .dy(dy), .valid(valid));

  function automatic logic [3:0] mag(input logic signed [3:0] v);
    return v[3] ? 4'(-v) : v;
  endfunction

  function automatic logic off_brd(input logic signed [3:0] v);
    return (v < 4'sd0) || (v > BMAX);
  endfunction

  assign last = (mv_indx == LAST);
  assign nx   = $signed({1'b0, cur_x}) + dx;
  assign ny   = $signed({1'b0, cur_y}) + dy;

  assign bus.cmd     = tour_active ? cmd_int     : bus.cmd_UART;
  assign bus.cmd_rdy = tour_active ? cmd_rdy_int : bus.cmd_rdy_UART;
  assign bus.resp    = (!tour_active || (state == WAIT_H && last)) ? RESP_POS : RESP_MOVE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mv_indx     <= '0;
      cur_x       <= '0;
      cur_y       <= '0;
      cmd_int     <= '0;
      cmd_rdy_int <= 1'b0;
      tour_active <= 1'b0;
      mv_err      <= 1'b0;
    end else begin
      mv_err <= 1'b0;
      case (state)
        IDLE: if (start_tour) begin
          cur_x       <= x_start;
          cur_y       <= y_start;
          mv_indx     <= '0;
          tour_active <= 1'b1;
          state       <= VERT;
        end
        VERT: if (!valid) begin
          mv_err      <= 1'b1;
          tour_active <= 1'b0;
          cmd_rdy_int <= 1'b0;
          state       <= IDLE;
        end else begin
          cmd_int <= {OP_MOVE, dy[3] ? HDG_S : HDG_N, mag(dy)};
          // A take only counts once cmd_rdy is visible to cmd_proc.
          if (cmd_rdy_int && bus.clr_cmd_rdy) begin
            cmd_rdy_int <= 1'b0;
            state       <= WAIT_V;
          end else cmd_rdy_int <= 1'b1;
        end
        WAIT_V: if (bus.send_resp) begin
          cur_y  <= ny[2:0];
          mv_err <= off_brd(ny);
          state  <= HORZ;
        end
        HORZ: begin
          cmd_int <= {last ? OP_FANFARE : OP_MOVE, dx[3] ? HDG_W : HDG_E, mag(dx)};
          if (cmd_rdy_int && bus.clr_cmd_rdy) begin
            cmd_rdy_int <= 1'b0;
            state       <= WAIT_H;
          end else cmd_rdy_int <= 1'b1;
        end
        WAIT_H: if (bus.send_resp) begin
          cur_x  <= nx[2:0];
          mv_err <= off_brd(nx);
          if (last) begin
            tour_active <= 1'b0;
            state       <= IDLE;
          end else begin
            mv_indx <= mv_indx + 5'd1;
            state   <= VERT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
